serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 154 +++++++++++++++
 tb/tb_serial_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out frame transmitter.
// Each frame is one start bit (low), DATA_WIDTH payload bits sent LSB first,
// and one stop bit (high). Every bit is held on tx for CLKS_PER_BIT clocks.
// The line idles high.
//
// Handshake: a word is taken on any rising edge where valid && ready.
// ready is high only while idle. valid and data are ignored at all other
// times, and valid does not need to be held once the word has been taken.
//
// state_o exposes the FSM state for debug and for bound checkers:
// 0 = IDLE, 1 = START, 2 = DATA, 3 = STOP.
module serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_o
);

  // Counter widths are just large enough to hold CLKS_PER_BIT-1 and
  // DATA_WIDTH-1. Both are kept at least one bit wide so that degenerate
  // parameter values still elaborate.
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH   > 1) ? $clog2(DATA_WIDTH)   : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e                  state_q;
  logic                    tx_q;
  logic                    busy_q;
  logic                    done_q;
  logic [BAUD_W-1:0]       baud_q;
  logic [BIT_W-1:0]        bit_q;
  logic [DATA_WIDTH-1:0]   shift_q;

  // Helper signals derived from the current state.
  logic                    bit_end;
  logic [DATA_WIDTH-1:0]   shift_d;

  // bit_end marks the last clock of the bit currently on the line.
  // shift_d moves the next payload bit down into position 0.
  assign bit_end = (baud_q == BAUD_LAST);
  assign shift_d = shift_q >> 1;

  // Main FSM. The counters are cleared on every state change, so they can
  // never carry a stale count from one state into the next. tx, busy and
  // done are registered here, which keeps valid and data away from tx.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      // done lasts exactly one cycle: the first IDLE cycle after STOP.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid) begin
            // Capture the word. From here on the latched copy is the only
            // source of payload bits, so later changes on data have no effect.
            shift_q <= data;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end else begin
            tx_q <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            // Put payload bit 0 on the line and line up bit 1 behind it.
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_d;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == BIT_LAST) begin
              // The last payload bit has had its full time; send the stop bit.
              bit_q   <= '0;
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + BIT_ONE;
              tx_q    <= shift_q[0];
              shift_q <= shift_d;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            tx_q    <= 1'b1;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end

        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          baud_q  <= '0;
          bit_q   <= '0;
        end
      endcase
    end
  end

  // ready depends only on the state. This lets a word be taken in the done
  // cycle, so frames can run back to back.
  assign ready   = (state_q == IDLE);
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: self-checking bench for serial_tx.
// dut_a uses the default parameters. dut_b is the small parameter sweep
// with DATA_WIDTH=4 and CLKS_PER_BIT=2.
module tb_serial_tx;

  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int FRAME = (DW + 2) * CPB;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, valid, ready, tx, busy, done;
  logic [DW-1:0] data;
  logic [1:0]    st_a;

  logic          rst_b, valid_b, ready_b, tx_b, busy_b, done_b;
  logic [3:0]    data_b;
  logic [1:0]    st_b;

  serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready),
    .tx(tx), .busy(busy), .done(done), .state_o(st_a)
  );

  serial_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(2)) dut_b (
    .clk(clk), .rst(rst_b), .data(data_b), .valid(valid_b), .ready(ready_b),
    .tx(tx_b), .busy(busy_b), .done(done_b), .state_o(st_b)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // A frame is described by the cycle just before it was accepted (m_t0)
  // and the captured word. Every output follows from the offset into that
  // frame, using plain arithmetic.
  logic          m_act  = 1'b0;
  int            m_t0   = 0;
  logic [DW-1:0] m_word = '0;

  function automatic logic model_tx_bit(input int off);
    int idx;
    idx = (off - 1) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= DW) return m_word[idx-1];
    return 1'b1;
  endfunction

  // Packed as {tx, busy, done, ready}.
  function automatic logic [3:0] model_out();
    int off;
    off = cyc - m_t0;
    if (m_act && off >= 1 && off <= FRAME) return {model_tx_bit(off), 3'b100};
    if (m_act && off == FRAME + 1) return 4'b1011;
    return 4'b1001;
  endfunction

  function automatic logic model_ready();
    int off;
    off = cyc - m_t0;
    return !(m_act && off >= 1 && off <= FRAME);
  endfunction

  // ---------------- driver ----------------
  // Call at a negedge. Drives one cycle of inputs, advances the model across
  // the rising edge, then samples and checks all outputs at the next negedge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, output logic [3:0] got);
    logic rdy;
    valid = v;
    data  = d;
    rst   = r;
    rdy   = model_ready();
    @(posedge clk);
    cyc++;
    if (r) m_act = 1'b0;
    else if (v && rdy) begin
      m_act  = 1'b1;
      m_t0   = cyc - 1;
      m_word = d;
    end
    @(negedge clk);
    got = {tx, busy, done, ready};
    check("cycle", 64'(got), 64'(model_out()));
  endtask

  // Sends one word and then runs FRAME more cycles, ending on the done cycle.
  // When noise is set, valid toggles at random and data is forced to 8'hFF
  // while the frame is in flight.
  task automatic send_frame(input logic [DW-1:0] d, input logic noise,
                            output logic [FRAME-1:0] line, output int busy_cnt,
                            output int done_cnt, output int done_pos);
    logic [3:0] g;
    logic       v;
    logic [DW-1:0] dd;
    busy_cnt = 0; done_cnt = 0; done_pos = 0; line = '0;
    for (int i = 0; i <= FRAME; i++) begin
      if (i == 0) begin
        v = 1'b1; dd = d;
      end else begin
        v  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        dd = noise ? 8'hFF : 8'($urandom);
      end
      step(v, dd, 1'b0, g);
      if (i < FRAME) line[i] = g[3];
      busy_cnt += int'(g[2]);
      if (g[1]) begin
        done_cnt++;
        done_pos = i + 1;
      end
    end
  endtask

  // Expands a 10-bit frame (first bit in the MSB) to one tx sample per cycle.
  function automatic logic [FRAME-1:0] expand(input logic [9:0] seq);
    logic [FRAME-1:0] e;
    for (int i = 0; i < FRAME; i++) e[i] = seq[9 - i / CPB];
    return e;
  endfunction

  task automatic check_frame(input string name, input logic [DW-1:0] d,
                             input logic noise, input logic [9:0] seq);
    logic [FRAME-1:0] line;
    int bc, dc, dp;
    send_frame(d, noise, line, bc, dc, dp);
    check({name, "_tx"}, 64'(line), 64'(expand(seq)));
    check({name, "_busy_cycles"}, 64'(bc), 64'(FRAME));
    check({name, "_done_count"}, 64'(dc), 64'd1);
    check({name, "_done_pos"}, 64'(dp), 64'(FRAME + 1));
  endtask

  // ---------------- vector table ----------------
  // seq holds the expected line bits in time order, first bit in the MSB:
  // start | payload LSB..MSB | stop.
  typedef struct {
    string         name;
    logic [DW-1:0] d;
    logic          noise;
    logic [9:0]    seq;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [3:0] g;
    int         dc, dpos[2];
    logic       tx41, tx42;
    logic [11:0] line_b;
    int         busy_b_cnt, done_b_cnt, done_b_pos;

    vecs[0] = '{"a5",       8'hA5, 1'b0, 10'b0_10100101_1};
    vecs[1] = '{"3c_noisy", 8'h3C, 1'b1, 10'b0_00111100_1};
    vecs[2] = '{"00",       8'h00, 1'b0, 10'b0_00000000_1};
    vecs[3] = '{"ff",       8'hFF, 1'b0, 10'b0_11111111_1};
    vecs[4] = '{"01",       8'h01, 1'b0, 10'b0_10000000_1};
    vecs[5] = '{"80",       8'h80, 1'b1, 10'b0_00000001_1};
    vecs[6] = '{"55",       8'h55, 1'b0, 10'b0_10101010_1};

    rst = 1'b1; valid = 1'b0; data = '0;
    rst_b = 1'b1; valid_b = 1'b0; data_b = '0;
    repeat (2) @(negedge clk);

    // Reset state of both instances.
    step(1'b0, '0, 1'b1, g);
    check("reset_a", 64'(g), 64'(4'b1001));
    check("reset_b", 64'({tx_b, busy_b, done_b, ready_b}), 64'(4'b1001));
    rst_b = 1'b0;

    // Long idle with valid low: the line stays high.
    for (int i = 0; i < 20; i++) step(1'b0, 8'($urandom), 1'b0, g);
    check("idle_hold", 64'(g), 64'(4'b1001));

    // Table-driven frames. Consecutive entries run back to back.
    for (int i = 0; i < 7; i++) check_frame(vecs[i].name, vecs[i].d, vecs[i].noise, vecs[i].seq);
    step(1'b0, '0, 1'b0, g);

    // Back-to-back: valid held high, 8'h01 first and then 8'h80.
    dc = 0; dpos[0] = 0; dpos[1] = 0; tx41 = 1'b0; tx42 = 1'b1;
    for (int k = 1; k <= 2 * FRAME + 2; k++) begin
      step(k <= FRAME + 2, (k == 1) ? 8'h01 : 8'h80, 1'b0, g);
      if (k == FRAME + 1) tx41 = g[3];
      if (k == FRAME + 2) tx42 = g[3];
      if (g[1]) begin
        if (dc < 2) dpos[dc] = k;
        dc++;
      end
    end
    check("b2b_done_count", 64'(dc), 64'd2);
    check("b2b_done_spacing", 64'(dpos[1] - dpos[0]), 64'(FRAME + 1));
    check("b2b_gap_high", 64'(tx41), 64'd1);
    check("b2b_second_start", 64'(tx42), 64'd0);
    step(1'b0, '0, 1'b0, g);

    // Reset during DATA bit 3 of 8'hF0 (bit 3 occupies cycles 17..20).
    step(1'b1, 8'hF0, 1'b0, g);
    for (int k = 2; k <= 18; k++) step(1'b0, 8'($urandom), 1'b0, g);
    step(1'b0, '0, 1'b1, g);
    check("rst_mid_frame", 64'(g), 64'(4'b1001));
    dc = 0;
    for (int k = 0; k < FRAME + 5; k++) begin
      step(1'b0, '0, 1'b0, g);
      dc += int'(g[1]);
    end
    check("rst_mid_no_done", 64'(dc), 64'd0);
    check_frame("after_rst_55", 8'h55, 1'b0, 10'b0_10101010_1);

    // rst and valid high on the same edge: no frame starts.
    step(1'b1, 8'hAA, 1'b1, g);
    check("rst_valid_same_edge", 64'(g), 64'(4'b1001));
    for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b0, g);
    check("rst_valid_no_frame", 64'(g[3:2]), 64'(2'b10));

    // A word offered on the first edge after rst drops is taken.
    step(1'b1, 8'hC3, 1'b1, g);
    check_frame("first_after_rst_5a", 8'h5A, 1'b0, 10'b0_01011010_1);

    // Random traffic with occasional resets, checked against the model.
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 199) == 0, g);
    for (int k = 0; k < FRAME + 2; k++) step(1'b0, '0, 1'b0, g);

    // Parameter sweep on dut_b: 4'b1001 gives tx 0 | 1,0,0,1 | 1 at 2 clocks per bit.
    valid_b = 1'b1; data_b = 4'b1001;
    @(posedge clk);
    @(negedge clk);
    valid_b = 1'b0; data_b = 4'b0110;
    busy_b_cnt = 0; done_b_cnt = 0; done_b_pos = 0; line_b = '0;
    for (int j = 0; j <= 12; j++) begin
      if (j < 12) line_b[j] = tx_b;
      busy_b_cnt += int'(busy_b);
      if (done_b) begin
        done_b_cnt++;
        done_b_pos = j + 1;
      end
      @(negedge clk);
    end
    check("sweep_tx", 64'(line_b), 64'(12'b1111_0000_1100));
    check("sweep_busy_cycles", 64'(busy_b_cnt), 64'd12);
    check("sweep_done_count", 64'(done_b_cnt), 64'd1);
    check("sweep_done_pos", 64'(done_b_pos), 64'd13);
    check("sweep_idle_after", 64'({tx_b, busy_b, ready_b}), 64'(3'b101));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
